// File: rtl/dsp_pkg.sv
// Constants shared by the DSP slice datapath stages: operand width,
// pre-adder opmode bit positions and pipeline register modes.
package dsp_pkg;

    localparam int WIDTH_B    = 18;

    localparam int PA_SUB_BIT = 1;
    localparam int PA_SEL_BIT = 0;

    localparam int REG_BYPASS = 0;
    localparam int REG_PIPE   = 1;

    // Any nonzero register parameter means a pipelined stage.
    function automatic int regMode(input int value);
        return (value != 0) ? REG_PIPE : REG_BYPASS;
    endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register with clock enable and async active-high reset;
// in bypass mode the output follows the input combinationally.
module dsp_pipe_reg
    import dsp_pkg::*;
#(
    parameter int WIDTH = WIDTH_B,
    parameter int REG   = REG_PIPE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_ce) begin
            r_q <= i_d;
        end
    end

    // The register is always built; bypass mode simply leaves it unloaded
    // so synthesis trims it away.
    assign o_q = (regMode(REG) == REG_PIPE) ? r_q : i_d;

endmodule

// File: rtl/b_preadd_stage.sv
// B-path B0/D registers, D +/- B pre-adder and B1 register feeding the
// multiplier and BCOUT. Define B_PREADD_CARRY_EN to add the PA_CARRY output.
module b_preadd_stage
    import dsp_pkg::*;
#(
    parameter int WIDTH = WIDTH_B,
    parameter int B0REG = 1,
    parameter int DREG  = 1,
    parameter int B1REG = 1
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             CEB,
    input  logic             CED,
    input  logic [WIDTH-1:0] B_IN,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       OPMODE_PA,
    output logic [WIDTH-1:0] B1_OUT,
    output logic [WIDTH-1:0] BCOUT
`ifdef B_PREADD_CARRY_EN
    ,
    output logic             PA_CARRY
`endif
);

    logic [WIDTH-1:0] w_b0;
    logic [WIDTH-1:0] w_dd;
    logic [WIDTH-1:0] w_pa;
    logic [WIDTH-1:0] w_m;

    dsp_pipe_reg #(.WIDTH(WIDTH), .REG(regMode(B0REG))) u_b0_reg (
        .i_clk (CLK),
        .i_rst (RSTB),
        .i_ce  (CEB),
        .i_d   (B_IN),
        .o_q   (w_b0)
    );

    dsp_pipe_reg #(.WIDTH(WIDTH), .REG(regMode(DREG))) u_d_reg (
        .i_clk (CLK),
        .i_rst (RSTB),
        .i_ce  (CED),
        .i_d   (D),
        .o_q   (w_dd)
    );

`ifdef B_PREADD_CARRY_EN
    logic [WIDTH:0] w_pa_ext;
    logic [WIDTH:0] w_m_ext;
    logic [WIDTH:0] w_b1_ext;

    // One extra bit holds the add carry or, for subtraction, the borrow
    // (set when b0 exceeds dd).
    assign w_pa_ext = OPMODE_PA[PA_SUB_BIT] ? ({1'b0, w_dd} - {1'b0, w_b0})
                                            : ({1'b0, w_dd} + {1'b0, w_b0});
    assign w_pa     = w_pa_ext[WIDTH-1:0];
    assign w_m      = OPMODE_PA[PA_SEL_BIT] ? w_pa : w_b0;
    assign w_m_ext  = {OPMODE_PA[PA_SEL_BIT] & w_pa_ext[WIDTH], w_m};

    dsp_pipe_reg #(.WIDTH(WIDTH + 1), .REG(regMode(B1REG))) u_b1_reg (
        .i_clk (CLK),
        .i_rst (RSTB),
        .i_ce  (CEB),
        .i_d   (w_m_ext),
        .o_q   (w_b1_ext)
    );

    assign B1_OUT   = w_b1_ext[WIDTH-1:0];
    assign PA_CARRY = w_b1_ext[WIDTH];
`else
    assign w_pa = OPMODE_PA[PA_SUB_BIT] ? (w_dd - w_b0) : (w_dd + w_b0);
    assign w_m  = OPMODE_PA[PA_SEL_BIT] ? w_pa : w_b0;

    dsp_pipe_reg #(.WIDTH(WIDTH), .REG(regMode(B1REG))) u_b1_reg (
        .i_clk (CLK),
        .i_rst (RSTB),
        .i_ce  (CEB),
        .i_d   (w_m),
        .o_q   (B1_OUT)
    );
`endif

    assign BCOUT = B1_OUT;

endmodule

// File: tb/tb_b_preadd_stage.sv
// Directed bench for b_preadd_stage: a fully pipelined instance and a fully
// combinational instance share the same stimulus.
module tb_b_preadd_stage;

    localparam int W = 18;

    logic         CLK;
    logic         RSTB;
    logic         CEB;
    logic         CED;
    logic [W-1:0] B_IN;
    logic [W-1:0] D;
    logic [1:0]   OPMODE_PA;

    logic [W-1:0] pipeB1;
    logic [W-1:0] pipeBc;
    logic [W-1:0] combB1;
    logic [W-1:0] combBc;

    int checks = 0;
    int errors = 0;

`ifdef B_PREADD_CARRY_EN
    logic pipeCarry;
    logic combCarry;
`endif

    b_preadd_stage #(.WIDTH(W), .B0REG(1), .DREG(1), .B1REG(1)) dutPipe (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .CEB       (CEB),
        .CED       (CED),
        .B_IN      (B_IN),
        .D         (D),
        .OPMODE_PA (OPMODE_PA),
        .B1_OUT    (pipeB1),
        .BCOUT     (pipeBc)
`ifdef B_PREADD_CARRY_EN
        ,
        .PA_CARRY  (pipeCarry)
`endif
    );

    b_preadd_stage #(.WIDTH(W), .B0REG(0), .DREG(0), .B1REG(0)) dutComb (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .CEB       (CEB),
        .CED       (CED),
        .B_IN      (B_IN),
        .D         (D),
        .OPMODE_PA (OPMODE_PA),
        .B1_OUT    (combB1),
        .BCOUT     (combBc)
`ifdef B_PREADD_CARRY_EN
        ,
        .PA_CARRY  (combCarry)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [W:0] observed,
                               input logic [W:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkPipe(input string tag, input logic [W-1:0] expected);
        checkOutput({tag, "_pipe_b1"}, {1'b0, pipeB1}, {1'b0, expected});
        checkOutput({tag, "_pipe_bc"}, {1'b0, pipeBc}, {1'b0, expected});
    endtask

    task automatic checkComb(input string tag, input logic [W-1:0] expected);
        checkOutput({tag, "_comb_b1"}, {1'b0, combB1}, {1'b0, expected});
        checkOutput({tag, "_comb_bc"}, {1'b0, combBc}, {1'b0, expected});
    endtask

    task automatic checkCarry(input string tag, input logic expPipe, input logic expComb);
`ifdef B_PREADD_CARRY_EN
        checkOutput({tag, "_pipe_cy"}, {{W{1'b0}}, pipeCarry}, {{W{1'b0}}, expPipe});
        checkOutput({tag, "_comb_cy"}, {{W{1'b0}}, combCarry}, {{W{1'b0}}, expComb});
`else
        if (expPipe === 1'bx || expComb === 1'bx) begin
            $display("[TB] carry argument undefined for %s", tag);
        end
`endif
    endtask

    task automatic applyStimulus(input logic [W-1:0] b, input logic [W-1:0] d,
                                 input logic [1:0] op);
        B_IN      = b;
        D         = d;
        OPMODE_PA = op;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset from time zero: pipelined outputs clear with no clock edge.
        RSTB = 1'b1;
        CEB  = 1'b1;
        CED  = 1'b1;
        applyStimulus(18'd5, 18'd10, 2'b01);
        #1;
        checkPipe("rst_async", 18'd0);
        checkComb("rst_comb", 18'd15);
        tick();
        checkPipe("rst_hold", 18'd0);
        RSTB = 1'b0;

        // Add 5 + 10 with two-edge latency.
        tick();
        checkPipe("add_lat1", 18'd0);
        tick();
        checkPipe("add_lat2", 18'd15);

        // Mid-stream reset discards in-flight data immediately.
        applyStimulus(18'd5, 18'd3, 2'b11);
        #3;
        RSTB = 1'b1;
        #1;
        checkPipe("rst_mid", 18'd0);
        checkComb("sub_wrap", 18'h3FFFE);
        tick();
        checkPipe("rst_mid_hold", 18'd0);
        RSTB = 1'b0;
        tick();
        checkPipe("post_rst1", 18'd0);
        tick();
        checkPipe("sub_wrap", 18'h3FFFE);
        checkCarry("sub_borrow", 1'b1, 1'b1);

        // Add wrap-around 3FFFF + 1.
        applyStimulus(18'd1, 18'h3FFFF, 2'b01);
        #1;
        checkComb("add_wrap", 18'd0);
        checkCarry("add_wrap_comb", 1'b1, 1'b1);
        tick();
        tick();
        checkPipe("add_wrap", 18'd0);
        checkCarry("add_carry", 1'b1, 1'b1);

        // Bypass: B0 value passes through regardless of D.
        applyStimulus(18'd7, 18'd123, 2'b00);
        #1;
        checkComb("bypass", 18'd7);
        tick();
        tick();
        checkPipe("bypass", 18'd7);
        checkCarry("bypass_carry", 1'b0, 1'b0);

        // B-path stall: B1 holds while D keeps loading.
        CEB = 1'b0;
        applyStimulus(18'd9, 18'd20, 2'b00);
        #1;
        checkComb("stall", 18'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkPipe("stall_hold", 18'd7);
        end

        // Resume with D frozen at 20: old b0 7 + 20 first, then 9 + 20.
        CEB = 1'b1;
        CED = 1'b0;
        applyStimulus(18'd9, 18'd0, 2'b01);
        #1;
        checkComb("resume", 18'd9);
        tick();
        checkPipe("resume1", 18'd27);
        tick();
        checkPipe("resume2", 18'd29);
        applyStimulus(18'd9, 18'd0, 2'b00);
        tick();
        checkPipe("resume_bypass", 18'd9);

        // Combinational instance: 4 + 6 in the same cycle.
        applyStimulus(18'd4, 18'd6, 2'b01);
        #1;
        checkComb("comb_add", 18'd10);
        checkCarry("comb_add_carry", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
